// File: rtl/y86_regfile_2w2r_if.sv
// y86_regfile_2w2r_if: decode read, writeback write and debug bus
// master drives addresses/write data, slave returns read data and the conflict flag
interface y86_regfile_2w2r_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              we_e;
   logic [ADDR_W-1:0] wa_e;
   logic [DATA_W-1:0] wd_e;
   logic              we_m;
   logic [ADDR_W-1:0] wa_m;
   logic [DATA_W-1:0] wd_m;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_data;
   logic              wr_conflict;

   modport master (
      output rd_addr_a, rd_addr_b,
      output we_e, wa_e, wd_e,
      output we_m, wa_m, wd_m,
      output dbg_addr,
      input  rd_data_a, rd_data_b,
      input  dbg_data, wr_conflict
   );

   modport slave (
      input  rd_addr_a, rd_addr_b,
      input  we_e, wa_e, wd_e,
      input  we_m, wa_m, wd_m,
      input  dbg_addr,
      output rd_data_a, rd_data_b,
      output dbg_data, wr_conflict
   );
endinterface

// File: rtl/y86_regfile_2w2r.sv
// y86_regfile_2w2r: Y86 register file, 2 clocked write ports (E, M), 2 decode reads
// ports: clk, rst (sync, active high), bus (slave): reads A/B, writes E/M, debug read, wr_conflict
module y86_regfile_2w2r #(
   parameter int              DATA_W      = 64,
   parameter int              ADDR_W      = 4,
   parameter int              NREGS       = 15,
   parameter logic [ADDR_W-1:0] RNONE     = {ADDR_W{1'b1}},
   parameter bit              RESET_INDEX = 1'b1,
   parameter bit              BYPASS      = 1'b1
) (
   input logic              clk,
   input logic              rst,
   y86_regfile_2w2r_if.slave bus
);

   localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [ADDR_W:0] NREGS_W = (ADDR_W + 1)'(NREGS);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic              conflict_q;
   logic              conflict_d;

   logic              wr_e;
   logic              wr_m;
   logic              byp_en;
   logic [IDX_W-1:0]  idx_e;
   logic [IDX_W-1:0]  idx_m;

   function automatic logic valid(input logic [ADDR_W-1:0] a);
      return (a != RNONE) && ({1'b0, a} < NREGS_W);
   endfunction

   // Array-only lookup; unimplemented indices read as zero.
   function automatic logic [DATA_W-1:0] arr(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = '0;
      if (valid(a))
         v = regs_q[a[IDX_W-1:0]];
      return v;
   endfunction

   // Decode read: M beats E so popq sees the loaded value.
   function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = arr(a);
      if (byp_en && valid(a)) begin
         if (bus.we_m && bus.wa_m == a)
            v = bus.wd_m;
         else if (bus.we_e && bus.wa_e == a)
            v = bus.wd_e;
      end
      return v;
   endfunction

   assign byp_en = BYPASS && !rst;
   assign wr_e   = bus.we_e && valid(bus.wa_e);
   assign wr_m   = bus.we_m && valid(bus.wa_m);
   assign idx_e  = bus.wa_e[IDX_W-1:0];
   assign idx_m  = bus.wa_m[IDX_W-1:0];

   assign conflict_d = wr_e && wr_m && (bus.wa_e == bus.wa_m);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            regs_q[i] <= RESET_INDEX ? DATA_W'(i) : '0;
         conflict_q <= 1'b0;
      end else begin
         if (wr_e)
            regs_q[idx_e] <= bus.wd_e;
         // Later assignment wins on a same-register dual write.
         if (wr_m)
            regs_q[idx_m] <= bus.wd_m;
         conflict_q <= conflict_d;
      end
   end

   assign bus.rd_data_a   = rd(bus.rd_addr_a);
   assign bus.rd_data_b   = rd(bus.rd_addr_b);
   assign bus.dbg_data    = arr(bus.dbg_addr);
   assign bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_y86_regfile_2w2r.sv
// tb_y86_regfile_2w2r: three parameterisations driven in lockstep
// against an array model, plus literal checks from the directed scenarios
module tb_y86_regfile_2w2r;

   localparam int NI = 3;
   localparam int NR [NI] = '{15, 8, 15};
   localparam bit RI [NI] = '{1'b1, 1'b1, 1'b0};
   localparam bit BY [NI] = '{1'b1, 1'b0, 1'b1};

   logic        clk = 1'b0;
   logic        rst;
   logic        started;
   logic [3:0]  ra, rb, wa_e, wa_m, dbg;
   logic        we_e, we_m;
   logic [63:0] wd_e, wd_m;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   y86_regfile_2w2r_if #(.DATA_W(64), .ADDR_W(4)) bus0 ();
   y86_regfile_2w2r_if #(.DATA_W(64), .ADDR_W(4)) bus1 ();
   y86_regfile_2w2r_if #(.DATA_W(64), .ADDR_W(4)) bus2 ();

   assign bus0.rd_addr_a = ra;   assign bus1.rd_addr_a = ra;   assign bus2.rd_addr_a = ra;
   assign bus0.rd_addr_b = rb;   assign bus1.rd_addr_b = rb;   assign bus2.rd_addr_b = rb;
   assign bus0.we_e = we_e;      assign bus1.we_e = we_e;      assign bus2.we_e = we_e;
   assign bus0.wa_e = wa_e;      assign bus1.wa_e = wa_e;      assign bus2.wa_e = wa_e;
   assign bus0.wd_e = wd_e;      assign bus1.wd_e = wd_e;      assign bus2.wd_e = wd_e;
   assign bus0.we_m = we_m;      assign bus1.we_m = we_m;      assign bus2.we_m = we_m;
   assign bus0.wa_m = wa_m;      assign bus1.wa_m = wa_m;      assign bus2.wa_m = wa_m;
   assign bus0.wd_m = wd_m;      assign bus1.wd_m = wd_m;      assign bus2.wd_m = wd_m;
   assign bus0.dbg_addr = dbg;   assign bus1.dbg_addr = dbg;   assign bus2.dbg_addr = dbg;

   logic [63:0] o_ra [NI];
   logic [63:0] o_rb [NI];
   logic [63:0] o_dbg [NI];
   logic        o_cf [NI];

   assign o_ra[0] = bus0.rd_data_a;  assign o_rb[0] = bus0.rd_data_b;
   assign o_ra[1] = bus1.rd_data_a;  assign o_rb[1] = bus1.rd_data_b;
   assign o_ra[2] = bus2.rd_data_a;  assign o_rb[2] = bus2.rd_data_b;
   assign o_dbg[0] = bus0.dbg_data;  assign o_cf[0] = bus0.wr_conflict;
   assign o_dbg[1] = bus1.dbg_data;  assign o_cf[1] = bus1.wr_conflict;
   assign o_dbg[2] = bus2.dbg_data;  assign o_cf[2] = bus2.wr_conflict;

   y86_regfile_2w2r #(.NREGS(15), .RESET_INDEX(1'b1), .BYPASS(1'b1))
      dut0 (.clk(clk), .rst(rst), .bus(bus0));
   y86_regfile_2w2r #(.NREGS(8), .RESET_INDEX(1'b1), .BYPASS(1'b0))
      dut1 (.clk(clk), .rst(rst), .bus(bus1));
   y86_regfile_2w2r #(.NREGS(15), .RESET_INDEX(1'b0), .BYPASS(1'b1))
      dut2 (.clk(clk), .rst(rst), .bus(bus2));

   // Reference state: one register image per instance.
   logic [63:0] mem [NI][16];
   logic        exp_cf [NI];

   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (rst) begin
            for (int i = 0; i < NR[k]; i++)
               mem[k][i] <= RI[k] ? 64'(i) : 64'd0;
            exp_cf[k] <= 1'b0;
         end else begin
            if (we_e && int'(wa_e) < NR[k]) mem[k][wa_e] <= wd_e;
            if (we_m && int'(wa_m) < NR[k]) mem[k][wa_m] <= wd_m;
            exp_cf[k] <= we_e && we_m && (wa_e == wa_m) && (int'(wa_e) < NR[k]);
         end
      end
   end

   function automatic logic [63:0] exp_rd(input int k, input logic [3:0] a,
                                          input bit use_byp);
      if (int'(a) >= NR[k]) return 64'd0;
      if (use_byp && BY[k] && !rst) begin
         if (we_m && wa_m == a) return wd_m;
         if (we_e && wa_e == a) return wd_e;
      end
      return mem[k][a];
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         for (int k = 0; k < NI; k++) begin
            chk($sformatf("model rd_a[%0d]", k), o_ra[k], exp_rd(k, ra, 1'b1));
            chk($sformatf("model rd_b[%0d]", k), o_rb[k], exp_rd(k, rb, 1'b1));
            chk($sformatf("model dbg[%0d]", k), o_dbg[k], exp_rd(k, dbg, 1'b0));
            chk($sformatf("model cf[%0d]", k), {63'd0, o_cf[k]}, {63'd0, exp_cf[k]});
         end
      end
   end

   task automatic idle();
      we_e = 1'b0; wa_e = 4'd0; wd_e = 64'd0;
      we_m = 1'b0; wa_m = 4'd0; wd_m = 64'd0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      started = 1'b0;
      rst = 1'b1;
      ra = 4'd0; rb = 4'd0; dbg = 4'd0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      started = 1'b1;

      // Reset image sweep.
      for (int i = 0; i < 16; i++) begin
         dbg = 4'(i); ra = 4'(i);
         #3;
         chk("rst dbg idx", o_dbg[0], (i < 15) ? 64'(i) : 64'd0);
         chk("rst rd_a idx", o_ra[0], (i < 15) ? 64'(i) : 64'd0);
         chk("rst dbg zero", o_dbg[2], 64'd0);
         chk("rst conflict", {63'd0, o_cf[0]}, 64'd0);
         step();
      end

      // Single write with same-cycle read.
      we_e = 1'b1; wa_e = 4'd3; wd_e = 64'hDEAD_BEEF; ra = 4'd3;
      #3;
      chk("bypass E", o_ra[0], 64'hDEAD_BEEF);
      chk("no bypass", o_ra[1], 64'd3);
      step();
      idle(); dbg = 4'd3;
      #3;
      chk("wrote R3", o_dbg[0], 64'hDEAD_BEEF);
      chk("wrote R3 n8", o_dbg[1], 64'hDEAD_BEEF);
      step();

      // popq: both ports hit R4, M wins.
      we_e = 1'b1; wa_e = 4'd4; wd_e = 64'h108;
      we_m = 1'b1; wa_m = 4'd4; wd_m = 64'h55; rb = 4'd4;
      #3;
      chk("popq bypass", o_rb[0], 64'h55);
      chk("popq cf pre", {63'd0, o_cf[0]}, 64'd0);
      step();
      idle(); dbg = 4'd4;
      #3;
      chk("popq R4", o_dbg[0], 64'h55);
      chk("popq cf", {63'd0, o_cf[0]}, 64'd1);
      step();
      #3;
      chk("popq cf drop", {63'd0, o_cf[0]}, 64'd0);
      step();

      // Distinct dual write.
      we_e = 1'b1; wa_e = 4'd4; wd_e = 64'h100;
      we_m = 1'b1; wa_m = 4'd0; wd_m = 64'h77;
      step();
      idle(); dbg = 4'd4; ra = 4'd0;
      #3;
      chk("dual R4", o_dbg[0], 64'h100);
      chk("dual R0", o_ra[0], 64'h77);
      chk("dual cf", {63'd0, o_cf[0]}, 64'd0);
      step();

      // RNONE and out-of-range.
      we_e = 1'b1; wa_e = 4'd15; wd_e = 64'h1234; ra = 4'd15;
      #3;
      chk("rnone rd", o_ra[0], 64'd0);
      step();
      wa_e = 4'd9; wd_e = 64'h999; ra = 4'd9;
      #3;
      chk("oor rd n8", o_ra[1], 64'd0);
      chk("idx9 bypass", o_ra[0], 64'h999);
      step();
      idle(); dbg = 4'd9;
      #3;
      chk("oor dbg n8", o_dbg[1], 64'd0);
      chk("idx9 dbg", o_dbg[0], 64'h999);
      step();

      // Reset overrides a write in the same cycle.
      we_e = 1'b1; wa_e = 4'd2; wd_e = 64'hAA;
      step();
      rst = 1'b1; wd_e = 64'hBB; ra = 4'd2;
      #3;
      chk("rst no bypass", o_ra[0], 64'hAA);
      step();
      rst = 1'b0; idle(); dbg = 4'd2;
      #3;
      chk("rst R2", o_dbg[0], 64'd2);
      chk("rst R2 zero", o_dbg[2], 64'd0);
      step();

      // Randomised traffic; model compare covers every cycle.
      for (int n = 0; n < 600; n++) begin
         rst  = ($urandom_range(0, 40) == 0);
         we_e = 1'($urandom_range(0, 1));
         we_m = 1'($urandom_range(0, 1));
         wa_e = 4'($urandom_range(0, 15));
         wa_m = ($urandom_range(0, 2) == 0) ? wa_e : 4'($urandom_range(0, 15));
         wd_e = {$urandom, $urandom};
         wd_m = {$urandom, $urandom};
         ra   = ($urandom_range(0, 1) == 0) ? wa_e : 4'($urandom_range(0, 15));
         rb   = ($urandom_range(0, 1) == 0) ? wa_m : 4'($urandom_range(0, 15));
         dbg  = 4'($urandom_range(0, 15));
         step();
      end

      rst = 1'b0;
      idle();
      step();
      started = 1'b0;
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
